// File: rtl/sys_pe_mac.sv
// sys_pe_mac: output-stationary processing element for the systolic matrix-multiply array.
// Pipelined a*b products are summed per tile; finished sums move to a result register.
module sys_pe_mac #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int MULT_LAT = 4,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              valid_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              last_out,
    output logic [ACC_W-1:0]  c,
    output logic              c_valid,
    output logic              c_ovf
);

    localparam int PROD_W = 2 * DATA_W;

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("sys_pe_mac: ACC_W must be at least 2*DATA_W");
    end
    if (MULT_LAT < 1) begin : g_bad_mult_lat
        $error("sys_pe_mac: MULT_LAT must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   prod_q [MULT_LAT];
    logic [MULT_LAT-1:0] vld_q;
    logic [MULT_LAT-1:0] last_q;
    logic                retire;
    logic                retire_last;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    ext;
    logic [ACC_W:0]      sum_full;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    sat_val;
    logic [ACC_W-1:0]    acc_add;
    logic                add_ovf;
    logic                ovf_sticky;
    logic                ovf_next;
    logic                done;
    logic [ACC_W-1:0]    done_val;
    logic                done_ovf;

    assign retire      = vld_q[MULT_LAT-1];
    assign retire_last = last_q[MULT_LAT-1];

    // Operands are widened to the product width first so the low 2*DATA_W bits are exact.
    always_comb begin
        if (SIGNED != 0) begin
            prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        end else begin
            prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a value on every path first; otherwise a latch is inferred.
        ext      = '0;
        add_ovf  = 1'b0;
        sat_val  = '1;
        if (SIGNED != 0) begin
            ext = ACC_W'($signed(prod_q[MULT_LAT-1]));
        end else begin
            ext = ACC_W'(prod_q[MULT_LAT-1]);
        end
        sum_full = {1'b0, acc} + {1'b0, ext};
        sum      = sum_full[ACC_W-1:0];
        if (SIGNED != 0) begin
            add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
            sat_val = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_ovf = sum_full[ACC_W];
        end
        acc_add = (add_ovf && (SATURATE != 0)) ? sat_val : sum;
    end

    // Accumulator FSM: only edges where a valid product retires move it.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        ovf_next   = ovf_sticky;
        done       = 1'b0;
        done_val   = acc;
        done_ovf   = ovf_sticky;
        if (retire) begin
            case (state)
                EMPTY: begin
                    acc_next   = ext;
                    ovf_next   = 1'b0;
                    done       = retire_last;
                    done_val   = ext;
                    done_ovf   = 1'b0;
                    state_next = retire_last ? EMPTY : ACCUM;
                end
                ACCUM: begin
                    acc_next   = acc_add;
                    ovf_next   = ovf_sticky | add_ovf;
                    done       = retire_last;
                    done_val   = acc_add;
                    done_ovf   = ovf_sticky | add_ovf;
                    state_next = retire_last ? EMPTY : ACCUM;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= EMPTY;
            vld_q      <= '0;
            last_q     <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            c          <= '0;
            c_valid    <= 1'b0;
            c_ovf      <= 1'b0;
        end else if (clr) begin
            state      <= EMPTY;
            vld_q      <= '0;
            last_q     <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            c_valid    <= 1'b0;
        end else if (en) begin
            vld_q[0]  <= valid_in;
            last_q[0] <= valid_in & last_in;
            for (int i = 1; i < MULT_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
            state      <= state_next;
            acc        <= acc_next;
            ovf_sticky <= ovf_next;
            a_out      <= a;
            b_out      <= b;
            valid_out  <= valid_in;
            last_out   <= last_in;
            c_valid    <= done;
            if (done) begin
                c     <= done_val;
                c_ovf <= done_ovf;
            end
        end
    end

    // NOTE: product data is not reset; the reset valid bits alone decide whether a stage is live.
    always_ff @(posedge CLK) begin
        if (en && !clr) begin
            prod_q[0] <= prod;
            for (int i = 1; i < MULT_LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sys_pe_mac.sv
// tb_sys_pe_mac: four builds of sys_pe_mac share one stimulus stream; each is checked every
// cycle against a tile-level arithmetic model (sums in longint, clamp or modulo per build).
module tb_sys_pe_mac;

    localparam int LAT = 4;

    logic       CLK      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       clr      = 1'b0;
    logic       valid_in = 1'b0;
    logic       last_in  = 1'b0;
    logic [7:0] a        = '0;
    logic [7:0] b        = '0;

    logic [7:0]  ao [4];
    logic [7:0]  bo [4];
    logic        vo [4];
    logic        lo [4];
    logic        cv [4];
    logic        cf [4];
    logic [31:0] c_u32;
    logic [31:0] c_s32;
    logic [15:0] c_sat16;
    logic [15:0] c_wrap16;

    always #5 CLK = ~CLK;

    sys_pe_mac #(.DATA_W(8), .ACC_W(32), .MULT_LAT(LAT), .SIGNED(0), .SATURATE(1)) u_u32 (
        .CLK(CLK), .rst(rst), .en(en), .clr(clr), .valid_in(valid_in), .last_in(last_in),
        .a(a), .b(b), .a_out(ao[0]), .b_out(bo[0]), .valid_out(vo[0]), .last_out(lo[0]),
        .c(c_u32), .c_valid(cv[0]), .c_ovf(cf[0]));

    sys_pe_mac #(.DATA_W(8), .ACC_W(32), .MULT_LAT(LAT), .SIGNED(1), .SATURATE(1)) u_s32 (
        .CLK(CLK), .rst(rst), .en(en), .clr(clr), .valid_in(valid_in), .last_in(last_in),
        .a(a), .b(b), .a_out(ao[1]), .b_out(bo[1]), .valid_out(vo[1]), .last_out(lo[1]),
        .c(c_s32), .c_valid(cv[1]), .c_ovf(cf[1]));

    sys_pe_mac #(.DATA_W(8), .ACC_W(16), .MULT_LAT(LAT), .SIGNED(0), .SATURATE(1)) u_sat16 (
        .CLK(CLK), .rst(rst), .en(en), .clr(clr), .valid_in(valid_in), .last_in(last_in),
        .a(a), .b(b), .a_out(ao[2]), .b_out(bo[2]), .valid_out(vo[2]), .last_out(lo[2]),
        .c(c_sat16), .c_valid(cv[2]), .c_ovf(cf[2]));

    sys_pe_mac #(.DATA_W(8), .ACC_W(16), .MULT_LAT(LAT), .SIGNED(0), .SATURATE(0)) u_wrap16 (
        .CLK(CLK), .rst(rst), .en(en), .clr(clr), .valid_in(valid_in), .last_in(last_in),
        .a(a), .b(b), .a_out(ao[3]), .b_out(bo[3]), .valid_out(vo[3]), .last_out(lo[3]),
        .c(c_wrap16), .c_valid(cv[3]), .c_ovf(cf[3]));

    // Build table: accumulator width, signedness, saturation.
    int cfg_w   [4] = '{32, 32, 16, 16};
    bit cfg_sgn [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit cfg_sat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [31:0]       edge_at;
        logic [3:0][31:0]  c;
        logic [3:0]        ovf;
    } compl_t;

    int checks = 0;
    int errors = 0;

    int           edge_cnt;
    logic [7:0]   cur_a [$];
    logic [7:0]   cur_b [$];
    compl_t       pend [$];
    logic [3:0][31:0] exp_c;
    logic [3:0]   exp_ovf;
    logic [3:0]   exp_cv;
    logic [7:0]   exp_ao;
    logic [7:0]   exp_bo;
    logic         exp_vo;
    logic         exp_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp_v);
        end
    endtask

    // Tile sum from the arithmetic rules: first product loads, later ones add with clamp or wrap.
    function automatic void tile_eval(input int w, input bit sgn, input bit sat,
                                      output logic [31:0] res, output logic ovf);
        longint m, lim_lo, lim_hi, acc, p;
        m = longint'(1) <<< w;
        if (sgn) begin
            lim_lo = -(m / 2);
            lim_hi = m / 2 - 1;
        end else begin
            lim_lo = 0;
            lim_hi = m - 1;
        end
        acc = 0;
        ovf = 1'b0;
        foreach (cur_a[i]) begin
            if (sgn) p = longint'($signed(cur_a[i])) * longint'($signed(cur_b[i]));
            else     p = longint'(cur_a[i]) * longint'(cur_b[i]);
            if (i == 0) begin
                acc = p;
            end else begin
                acc += p;
                if (acc > lim_hi || acc < lim_lo) begin
                    ovf = 1'b1;
                    if (sat) acc = (acc > lim_hi) ? lim_hi : lim_lo;
                    else     acc = ((acc - lim_lo) % m + m) % m + lim_lo;
                end
            end
        end
        res = acc[31:0];
    endfunction

    task automatic model_reset();
        edge_cnt = 0;
        cur_a.delete();
        cur_b.delete();
        pend.delete();
        exp_c   = '0;
        exp_ovf = '0;
        exp_cv  = '0;
        exp_ao  = '0;
        exp_bo  = '0;
        exp_vo  = 1'b0;
        exp_lo  = 1'b0;
    endtask

    task automatic model_edge();
        compl_t      t;
        logic [31:0] r;
        logic        o;
        if (clr) begin
            cur_a.delete();
            cur_b.delete();
            pend.delete();
            exp_cv = '0;
            exp_ao = '0;
            exp_bo = '0;
            exp_vo = 1'b0;
            exp_lo = 1'b0;
        end else if (en) begin
            edge_cnt++;
            exp_ao = a;
            exp_bo = b;
            exp_vo = valid_in;
            exp_lo = last_in;
            if (valid_in) begin
                cur_a.push_back(a);
                cur_b.push_back(b);
                if (last_in) begin
                    t = '0;
                    t.edge_at = 32'(edge_cnt + LAT);
                    for (int k = 0; k < 4; k++) begin
                        tile_eval(cfg_w[k], cfg_sgn[k], cfg_sat[k], r, o);
                        t.c[k]   = r;
                        t.ovf[k] = o;
                    end
                    pend.push_back(t);
                    cur_a.delete();
                    cur_b.delete();
                end
            end
            exp_cv = '0;
            if (pend.size() > 0 && pend[0].edge_at == 32'(edge_cnt)) begin
                t       = pend.pop_front();
                exp_c   = t.c;
                exp_ovf = t.ovf;
                exp_cv  = '1;
            end
        end
    endtask

    function automatic logic [31:0] c_of(input int k);
        case (k)
            0:       return c_u32;
            1:       return c_s32;
            2:       return {16'h0, c_sat16};
            default: return {16'h0, c_wrap16};
        endcase
    endfunction

    task automatic check_all();
        logic [31:0] ec;
        for (int k = 0; k < 4; k++) begin
            ec = (cfg_w[k] == 16) ? {16'h0, exp_c[k][15:0]} : exp_c[k];
            chk($sformatf("c_valid[%0d]", k), {31'h0, cv[k]}, {31'h0, exp_cv[k]});
            chk($sformatf("c[%0d]", k), c_of(k), ec);
            chk($sformatf("c_ovf[%0d]", k), {31'h0, cf[k]}, {31'h0, exp_ovf[k]});
            chk($sformatf("a_out[%0d]", k), {24'h0, ao[k]}, {24'h0, exp_ao});
            chk($sformatf("b_out[%0d]", k), {24'h0, bo[k]}, {24'h0, exp_bo});
            chk($sformatf("valid_out[%0d]", k), {31'h0, vo[k]}, {31'h0, exp_vo});
            chk($sformatf("last_out[%0d]", k), {31'h0, lo[k]}, {31'h0, exp_lo});
        end
    endtask

    task automatic cyc(input logic e, input logic cl, input logic v, input logic l,
                       input logic [7:0] av, input logic [7:0] bv);
        en       = e;
        clr      = cl;
        valid_in = v;
        last_in  = l;
        a        = av;
        b        = bv;
        @(posedge CLK);
        model_edge();
        #1 check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic t1_issue();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 8'd4);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd6);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd7, 8'd8);
    endtask

    initial begin
        model_reset();
        #2 check_all();
        chk("reset_c", c_u32, 32'd0);
        #10 rst = 1'b0;

        // Plain tile, then the same tile immediately followed by a two-pair tile.
        t1_issue();
        idle(6);
        chk("t1_c", c_u32, 32'd100);
        chk("t1_ovf", {31'h0, cf[0]}, 32'd0);
        t1_issue();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2);
        idle(6);
        chk("t2_c", c_u32, 32'd8);

        // Signed products, and 16-bit accumulator overflow in clamp and wrap builds.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hFD, 8'd5);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 8'hFE);
        idle(6);
        chk("t3_c_signed", c_s32, 32'hFFFF_FFE9);
        chk("t3_ovf_signed", {31'h0, cf[1]}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
        idle(6);
        chk("t4_c_sat", {16'h0, c_sat16}, 32'h0000_FFFF);
        chk("t4_ovf_sat", {31'h0, cf[2]}, 32'd1);
        chk("t4_c_wrap", {16'h0, c_wrap16}, 32'h0000_FC02);
        chk("t4_ovf_wrap", {31'h0, cf[3]}, 32'd1);

        // Three stalled cycles inside a tile; inputs wiggle but nothing may move.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 8'd4);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd6);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd7, 8'd8);
        idle(6);
        chk("t5_c", c_u32, 32'd100);

        // Flush mid-tile drops the tile; a re-issued tile completes normally.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 8'd4);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 8'd6);
        idle(8);
        t1_issue();
        idle(6);
        chk("t6_clr_c", c_u32, 32'd100);

        // Asynchronous reset mid-tile.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd9, 8'd9);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd9, 8'd9);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        chk("t6_rst_c", c_u32, 32'd0);
        #2 rst = 1'b0;
        t1_issue();
        idle(6);
        chk("t6_rst_then_c", c_u32, 32'd100);

        // Random traffic: stalls, occasional flushes, ignored last_in without valid_in.
        repeat (150) begin
            cyc(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                8'($urandom), 8'($urandom));
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
